// File: rtl/ultra_fetch_if.sv
// Fetch-stage bus: memory read port, instruction hand-off to decode, and
// control from execute.
interface ultra_fetch_if #(
   parameter int ADDR_W = 10
);
   logic              run;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [15:0]       ir_data;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic              halted;

   modport master (
      input  run, mem_rdata, ir_ready, redirect, redirect_pc, halt,
      output mem_rd, mem_addr, ir_data, ir_pc, ir_valid, halted
   );

   modport slave (
      output run, mem_rdata, ir_ready, redirect, redirect_pc, halt,
      input  mem_rd, mem_addr, ir_data, ir_pc, ir_valid, halted
   );
endinterface

// File: rtl/ultra_fetch.sv
// Instruction fetch for the 16-bit ultra CPU: two byte reads (high byte first)
// assembled big-endian, handed to decode over valid/ready; owns the PC.
module ultra_fetch #(
   parameter int ADDR_W   = 10,
   parameter int START_PC = 20
) (
   input logic           clock,
   input logic           reset,
   ultra_fetch_if.master bus
);
   typedef enum logic [2:0] {
      IDLE,
      REQ_HI,
      REQ_LO,
      WAIT_LO,
      VALID,
      STOP
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc, pc_next;
   logic [7:0]        hi, hi_next;
   logic [15:0]       ir_data, ir_data_next;
   logic [ADDR_W-1:0] ir_pc, ir_pc_next;
   logic              ir_valid, ir_valid_next;
   logic              halted, halted_next;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_next    = state;
      pc_next       = pc;
      hi_next       = hi;
      ir_data_next  = ir_data;
      ir_pc_next    = ir_pc;
      ir_valid_next = ir_valid;
      halted_next   = halted;
      mem_rd        = 1'b0;
      mem_addr      = '0;

      case (state)
         REQ_HI: begin
            mem_rd   = 1'b1;
            mem_addr = pc;
         end
         REQ_LO: begin
            mem_rd   = 1'b1;
            mem_addr = pc + ADDR_W'(1);
         end
         default: ;
      endcase

      // Priority: halt over redirect over the normal fetch sequence.
      if (bus.halt) begin
         state_next    = STOP;
         ir_valid_next = 1'b0;
         halted_next   = 1'b1;
      end else if (bus.redirect) begin
         pc_next       = bus.redirect_pc;
         ir_valid_next = 1'b0;
         halted_next   = 1'b0;
         state_next    = bus.run ? REQ_HI : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.run) state_next = REQ_HI;
            end
            REQ_HI: state_next = REQ_LO;
            REQ_LO: begin
               hi_next    = bus.mem_rdata;
               state_next = WAIT_LO;
            end
            WAIT_LO: begin
               ir_data_next  = {hi, bus.mem_rdata};
               ir_pc_next    = pc;
               ir_valid_next = 1'b1;
               state_next    = VALID;
            end
            VALID: begin
               if (ir_valid && bus.ir_ready) begin
                  ir_valid_next = 1'b0;
                  pc_next       = pc + ADDR_W'(2);
                  state_next    = bus.run ? REQ_HI : IDLE;
               end
            end
            STOP:    state_next = STOP;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state    <= IDLE;
         pc       <= ADDR_W'(START_PC);
         hi       <= '0;
         ir_data  <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         hi       <= hi_next;
         ir_data  <= ir_data_next;
         ir_pc    <= ir_pc_next;
         ir_valid <= ir_valid_next;
         halted   <= halted_next;
      end
   end

   assign bus.mem_rd   = mem_rd;
   assign bus.mem_addr = mem_addr;
   assign bus.ir_data  = ir_data;
   assign bus.ir_pc    = ir_pc;
   assign bus.ir_valid = ir_valid;
   assign bus.halted   = halted;
endmodule

// File: tb/tb_ultra_fetch.sv
// Table-driven bench for ultra_fetch: per-cycle vectors with hand-computed
// outputs, a 1K byte memory with 1-cycle read, and a halt/redirect sequence.
module tb_ultra_fetch;
   localparam int ADDR_W = 10;

   typedef struct {
      int reps;
      bit rst, run, rdy, redir;
      int rpc;
      bit hlt;
      bit e_rd;
      int e_addr;
      bit e_v;
      int e_d;
      int e_p;
      bit e_h;
   } vec_t;

   logic clock;
   logic reset;
   logic [7:0] mem [0:(1<<ADDR_W)-1];
   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs[$];

   ultra_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   ultra_fetch #(.ADDR_W(ADDR_W), .START_PC(20)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous byte memory: data appears the cycle after mem_rd.
   always @(posedge clock) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic vec_t mk(int reps, bit rst, bit run, bit rdy, bit redir, int rpc, bit hlt,
                               bit e_rd, int e_addr, bit e_v, int e_d, int e_p, bit e_h);
      vec_t v;
      v.reps = reps; v.rst = rst; v.run = run; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
      v.hlt = hlt; v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v; v.e_d = e_d; v.e_p = e_p;
      v.e_h = e_h;
      return v;
   endfunction

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, " mem_rd"},   32'(bus.mem_rd),   32'(v.e_rd));
      check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.e_addr));
      check({tag, " ir_valid"}, 32'(bus.ir_valid), 32'(v.e_v));
      check({tag, " ir_data"},  32'(bus.ir_data),  32'(v.e_d));
      check({tag, " ir_pc"},    32'(bus.ir_pc),    32'(v.e_p));
      check({tag, " halted"},   32'(bus.halted),   32'(v.e_h));
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'hEE;
      mem[20] = 8'h40; mem[21] = 8'h06; mem[22] = 8'h60; mem[23] = 8'h08;
      mem[24] = 8'h12; mem[25] = 8'h34; mem[40] = 8'h78; mem[41] = 8'h9A;
      mem[42] = 8'hBC; mem[43] = 8'hDE; mem[1023] = 8'hC0; mem[0] = 8'h00;
      mem[1] = 8'h11;  mem[2] = 8'h22;

      //            reps rst run rdy rd rpc  hlt | rd addr v  data     pc    h
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h0000, 0,    0)); // IDLE
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 20,   0, 'h0000, 0,    0)); // REQ_HI
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 21,   0, 'h0000, 0,    0)); // REQ_LO
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h0000, 0,    0)); // WAIT_LO
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    1, 'h4006, 20,   0)); // accept
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,   1, 22,   0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,   1, 23,   0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,   0, 0,    0, 'h4006, 20,   0));
      vecs.push_back(mk(5, 0, 1, 0, 0, 0,    0,   0, 0,    1, 'h6008, 22,   0)); // backpressure
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    1, 'h6008, 22,   0)); // accept
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 24,   0, 'h6008, 22,   0));
      vecs.push_back(mk(1, 0, 1, 1, 1, 40,   0,   1, 25,   0, 'h6008, 22,   0)); // redirect in REQ_LO
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 40,   0, 'h6008, 22,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 41,   0, 'h6008, 22,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h6008, 22,   0));
      vecs.push_back(mk(1, 0, 1, 1, 1, 1023, 0,   0, 0,    1, 'h789A, 40,   0)); // redirect + accept
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 1023, 0, 'h789A, 40,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 0,    0, 'h789A, 40,   0)); // lo byte wraps
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h789A, 40,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    1, 'hC000, 1023, 0)); // accept, pc -> 1
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 1,    0, 'hC000, 1023, 0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 2,    0, 'hC000, 1023, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,   0, 0,    0, 'hC000, 1023, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    1,   0, 0,    1, 'h1122, 1,    0)); // halt in VALID
      vecs.push_back(mk(10,0, 1, 1, 0, 0,    0,   0, 0,    0, 'h1122, 1,    1)); // STOP
      vecs.push_back(mk(1, 0, 1, 1, 1, 20,   0,   0, 0,    0, 'h1122, 1,    1)); // redirect leaves STOP
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 20,   0, 'h1122, 1,    0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 21,   0, 'h1122, 1,    0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 0,    0,   0, 0,    0, 'h1122, 1,    0)); // reset in WAIT_LO
      vecs.push_back(mk(2, 0, 0, 1, 0, 0,    0,   0, 0,    0, 'h0000, 0,    0)); // stale byte ignored
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h0000, 0,    0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,   1, 20,   0, 'h0000, 0,    0)); // run dropped
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,   1, 21,   0, 'h0000, 0,    0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,   0, 0,    0, 'h0000, 0,    0));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0,    0,   0, 0,    1, 'h4006, 20,   0)); // accept -> IDLE
      vecs.push_back(mk(2, 0, 0, 1, 0, 0,    0,   0, 0,    0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   0, 0,    0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 22,   0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 0,    0,   1, 23,   0, 'h4006, 20,   0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0,    0,   0, 0,    0, 'h4006, 20,   0));

      reset = 1'b1;
      bus.run = 1'b0; bus.ir_ready = 1'b0; bus.redirect = 1'b0;
      bus.redirect_pc = '0; bus.halt = 1'b0;
      step();
      step();
      check("reset ir_valid", 32'(bus.ir_valid), 32'd0);
      check("reset ir_data",  32'(bus.ir_data),  32'd0);
      check("reset ir_pc",    32'(bus.ir_pc),    32'd0);
      check("reset halted",   32'(bus.halted),   32'd0);
      check("reset mem_rd",   32'(bus.mem_rd),   32'd0);

      foreach (vecs[k]) begin
         for (int r = 0; r < vecs[k].reps; r++) begin
            reset           = vecs[k].rst;
            bus.run         = vecs[k].run;
            bus.ir_ready    = vecs[k].rdy;
            bus.redirect    = vecs[k].redir;
            bus.redirect_pc = ADDR_W'(vecs[k].rpc);
            bus.halt        = vecs[k].hlt;
            check_outputs($sformatf("vec%0d.%0d", k, r), vecs[k]);
            step();
         end
      end

      // Halt, redirect and accept all in one VALID cycle: halt must win.
      check("pre-halt ir_valid", 32'(bus.ir_valid), 32'd1);
      check("pre-halt ir_data",  32'(bus.ir_data),  32'h6008);
      bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 10'd40; bus.ir_ready = 1'b1;
      step();
      bus.halt = 1'b0; bus.redirect = 1'b0;
      check("halt-wins halted",   32'(bus.halted),   32'd1);
      check("halt-wins ir_valid", 32'(bus.ir_valid), 32'd0);
      check("halt-wins mem_rd",   32'(bus.mem_rd),   32'd0);
      step();
      check("stop mem_rd", 32'(bus.mem_rd), 32'd0);
      bus.redirect = 1'b1; bus.redirect_pc = 10'd42;
      step();
      bus.redirect = 1'b0;
      check("restart mem_addr", 32'(bus.mem_addr), 32'd42);
      check("restart halted",   32'(bus.halted),   32'd0);
      for (int i = 0; i < 10 && !bus.ir_valid; i++) step();
      check("restart ir_valid", 32'(bus.ir_valid), 32'd1);
      check("restart ir_data",  32'(bus.ir_data),  32'hBCDE);
      check("restart ir_pc",    32'(bus.ir_pc),    32'd42);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
